// File: rtl/dmem_responder.sv
// Data-memory responder: RV32I-sized loads/stores against a local word array.
// Latency: rsp_valid rises 1+WAIT_CYCLES edges after the accepting edge.
// Backpressure: holds the response until rsp_ready; takes one request at a time.
//
// Ports: clk, rst (async, active-low); req_valid/req_ready/req_we/req_addr/
// req_wdata/req_func3 request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err
// response channel.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  func3_q, func3_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          in_range, misaligned, bad_func, fault, mem_we;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, ld_data, st_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [3:0]    st_be;

    assign word_idx  = addr_q[AW+1:2];
    assign in_range  = ({2'b00, addr_q[31:2]} < DEPTH_L);
    assign rd_word   = in_range ? mem_q[word_idx] : '0;
    assign fault     = !in_range || misaligned || bad_func;
    // Storage is touched only on the edge that moves WAIT -> RESP.
    assign mem_we    = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !fault;

    // Size/sign decode of the captured request.
    always_comb begin
        case (addr_q[1:0])
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        misaligned = 1'b0;
        bad_func   = 1'b0;
        ld_data    = '0;
        st_data    = '0;
        st_be      = '0;
        case (func3_q)
            3'b000: begin
                ld_data = {{24{rd_byte[7]}}, rd_byte};
                st_data = {4{wdata_q[7:0]}};
                st_be   = 4'b0001 << addr_q[1:0];
            end
            3'b001: begin
                misaligned = addr_q[0];
                ld_data    = {{16{rd_half[15]}}, rd_half};
                st_data    = {2{wdata_q[15:0]}};
                st_be      = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                misaligned = (addr_q[1:0] != 2'b00);
                ld_data    = rd_word;
                st_data    = wdata_q;
                st_be      = 4'b1111;
            end
            3'b100: begin
                bad_func = we_q;
                ld_data  = {24'b0, rd_byte};
            end
            3'b101: begin
                bad_func   = we_q;
                misaligned = addr_q[0];
                ld_data    = {16'b0, rd_half};
            end
            default: bad_func = 1'b1;
        endcase
    end

    // Next-state logic. WAIT always lasts WAIT_CYCLES+1 cycles: one cycle for
    // the captured request plus WAIT_CYCLES wait states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    func3_d     = req_func3;
                    cnt_d       = WAIT_L;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = fault;
                    rsp_rdata_d = (fault || we_q) ? 32'd0 : ld_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
        end
    end

    // Storage has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem_q[word_idx][i*8 +: 8] <= st_data[i*8 +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
